tdm_clock_generator: RTL and testbench

Runtime-configurable serial-audio clock master. It generates BCLK plus a frame-sync/word-select line for I2S, left-justified and DSP/TDM framing, with 1..2^SLOT_IDX_W slots per frame. It also emits system-clock-domain strobes and bit/slot indices so transmit and receive shifters run synchronously in clk_i without sampling bclk_o. Configuration changes are applied only at frame boundaries, and stop is graceful at end of frame.

---
 rtl/i2s_pkg.sv | 52 +++++
 rtl/bclk_divider.sv | 60 ++++++
 rtl/tdm_clock_generator.sv | 138 +++++++++++++
 tb/tb_tdm_clock_generator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the TDM/I2S clock master: framing modes, the shadow
// configuration record and the word-select rule evaluated at each bit start.
package i2s_pkg;

    localparam int CFG_DIV_W      = 8;
    localparam int CFG_SLOT_W     = 6;
    localparam int CFG_SLOT_IDX_W = 3;

    typedef enum logic [1:0] {
        MODE_I2S  = 2'd0,
        MODE_LJ   = 2'd1,
        MODE_DSP  = 2'd2,
        MODE_RSVD = 2'd3
    } i2s_mode_e;

    typedef struct packed {
        logic [CFG_DIV_W-1:0]      div;
        logic [CFG_SLOT_W-1:0]     slot_len;
        logic [CFG_SLOT_IDX_W-1:0] num_slots;
        i2s_mode_e                 mode;
    } tdm_cfg_t;

    // Word-select value for the bit that starts at this falling edge.
    // The last slot of the first half is num_slots/2, i.e. (num_slots+2)/2 - 1.
    function automatic logic lrclk_next(input tdm_cfg_t                  cfg,
                                        input logic [CFG_SLOT_W-1:0]     bit_idx,
                                        input logic [CFG_SLOT_IDX_W-1:0] slot_idx,
                                        input logic                      cur);
        logic last_bit;
        logic res;
        last_bit = (bit_idx == cfg.slot_len);
        res      = cur;
        case (cfg.mode)
            MODE_LJ:  res = (slot_idx <= (cfg.num_slots >> 1));
            MODE_DSP: res = (bit_idx == '0) && (slot_idx == '0);
            default: begin
                // I2S leads each half by one bit; clearing wins when both
                // halves collapse onto slot 0 (single-slot frames).
                if (last_bit && (slot_idx == cfg.num_slots))
                    res = 1'b0;
                else if (last_bit && (slot_idx == (cfg.num_slots >> 1)))
                    res = 1'b1;
                else if ((bit_idx == '0) && (slot_idx == '0))
                    res = 1'b0;
                else
                    res = cur;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bclk_divider.sv
// Half-period down-counter producing BCLK and its registered edge strobes.
// fall_next_o tells the sequencer that the coming edge starts a new bit.
module bclk_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bclk_o,
    output logic             bclk_rise_o,
    output logic             bclk_fall_o,
    output logic             fall_next_o
);

    logic [DIV_W-1:0] cnt_q;
    logic             bclk_q;
    logic             rise_q;
    logic             fall_q;
    logic             running_q;

    assign bclk_o      = bclk_q;
    assign bclk_rise_o = rise_q;
    assign bclk_fall_o = fall_q;
    assign fall_next_o = running_q && bclk_q && (cnt_q == '0);

    // Count down each phase; toggle and reload at terminal count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            bclk_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            running_q <= 1'b0;
        end else if (!run_i) begin
            cnt_q     <= '0;
            bclk_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            running_q <= 1'b0;
        end else if (!running_q) begin
            // First bit after start begins with a low phase and a fall strobe.
            cnt_q     <= div_i;
            bclk_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b1;
            running_q <= 1'b1;
        end else if (cnt_q == '0) begin
            cnt_q  <= div_i;
            bclk_q <= ~bclk_q;
            rise_q <= ~bclk_q;
            fall_q <= bclk_q;
        end else begin
            cnt_q  <= cnt_q - 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end
    end

endmodule

// File: rtl/tdm_clock_generator.sv
// Serial-audio clock master: BCLK, word select / frame sync, and clk_i-domain
// bit/slot indices. Configuration is sampled only at frame boundaries and a
// stop request always lets the current frame finish.
module tdm_clock_generator
    import i2s_pkg::*;
#(
    parameter int DIV_W      = CFG_DIV_W,
    parameter int SLOT_W     = CFG_SLOT_W,
    parameter int SLOT_IDX_W = CFG_SLOT_IDX_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [DIV_W-1:0]      clk_div_i,
    input  logic [SLOT_W-1:0]     slot_len_i,
    input  logic [SLOT_IDX_W-1:0] num_slots_i,
    input  logic [1:0]            mode_i,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  bclk_rise_o,
    output logic                  bclk_fall_o,
    output logic [SLOT_W-1:0]     bit_idx_o,
    output logic [SLOT_IDX_W-1:0] slot_idx_o,
    output logic                  frame_start_o,
    output logic                  active_o
);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e                state_q;
    tdm_cfg_t              cfg_q;
    tdm_cfg_t              cfg_d;
    tdm_cfg_t              cfg_in;
    logic [SLOT_W-1:0]     bit_q, bit_d;
    logic [SLOT_IDX_W-1:0] slot_q, slot_d;
    logic                  lrclk_q, lrclk_d;
    logic                  frame_start_q;
    logic                  active_q;
    logic                  fall_next;
    logic                  last_bit, last_slot;
    logic                  start, boundary, stop, run;

    // Live configuration inputs gathered into the shadow record format.
    always_comb begin
        cfg_in           = '0;
        cfg_in.div       = clk_div_i;
        cfg_in.slot_len  = slot_len_i;
        cfg_in.num_slots = num_slots_i;
        cfg_in.mode      = i2s_mode_e'(mode_i);
    end

    // Position advance, frame-boundary detection and next word-select value.
    always_comb begin
        last_bit  = (bit_q == cfg_q.slot_len);
        last_slot = (slot_q == cfg_q.num_slots);
        start     = (state_q == ST_IDLE) && enable_i;
        boundary  = (state_q == ST_RUN) && fall_next && last_bit && last_slot;
        stop      = boundary && !enable_i;
        run       = start || ((state_q == ST_RUN) && !stop);
        cfg_d     = (start || (boundary && enable_i)) ? cfg_in : cfg_q;
        if (start || boundary) begin
            bit_d  = '0;
            slot_d = '0;
        end else if (last_bit) begin
            bit_d  = '0;
            slot_d = slot_q + 1'b1;
        end else begin
            bit_d  = bit_q + 1'b1;
            slot_d = slot_q;
        end
        lrclk_d = lrclk_next(cfg_d, bit_d, slot_d, lrclk_q);
    end

    // The divider reloads from cfg_d so a re-latched divider applies to the
    // very bit that starts the new frame.
    bclk_divider #(
        .DIV_W(DIV_W)
    ) u_bclk_divider (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .run_i      (run),
        .div_i      (cfg_d.div),
        .bclk_o     (bclk_o),
        .bclk_rise_o(bclk_rise_o),
        .bclk_fall_o(bclk_fall_o),
        .fall_next_o(fall_next)
    );

    // Sequencer: start, per-bit advance on falling edges, graceful stop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cfg_q         <= '0;
            bit_q         <= '0;
            slot_q        <= '0;
            lrclk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q       <= ST_RUN;
                        cfg_q         <= cfg_d;
                        bit_q         <= bit_d;
                        slot_q        <= slot_d;
                        lrclk_q       <= lrclk_d;
                        frame_start_q <= 1'b1;
                        active_q      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q  <= ST_IDLE;
                        bit_q    <= '0;
                        slot_q   <= '0;
                        lrclk_q  <= 1'b0;
                        active_q <= 1'b0;
                    end else if (fall_next) begin
                        cfg_q         <= cfg_d;
                        bit_q         <= bit_d;
                        slot_q        <= slot_d;
                        lrclk_q       <= lrclk_d;
                        frame_start_q <= boundary;
                    end
                end
            endcase
        end
    end

    assign lrclk_o       = lrclk_q;
    assign bit_idx_o     = bit_q;
    assign slot_idx_o    = slot_q;
    assign frame_start_o = frame_start_q;
    assign active_o      = active_q;

endmodule

// File: tb/tb_tdm_clock_generator.sv
// Bench for tdm_clock_generator: a frame-position model (bit position within
// the frame plus cycle within the bit) predicts every output each cycle;
// directed frame measurements pin periods and word-select placement.
module tb_tdm_clock_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] div = 8'd0;
    logic [5:0] slen = 6'd0;
    logic [2:0] nsl = 3'd0;
    logic [1:0] mode = 2'd0;

    logic       bclk_o, lrclk_o, bclk_rise_o, bclk_fall_o, frame_start_o, active_o;
    logic [5:0] bit_idx_o;
    logic [2:0] slot_idx_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_clock_generator dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .clk_div_i    (div),
        .slot_len_i   (slen),
        .num_slots_i  (nsl),
        .mode_i       (mode),
        .bclk_o       (bclk_o),
        .lrclk_o      (lrclk_o),
        .bclk_rise_o  (bclk_rise_o),
        .bclk_fall_o  (bclk_fall_o),
        .bit_idx_o    (bit_idx_o),
        .slot_idx_o   (slot_idx_o),
        .frame_start_o(frame_start_o),
        .active_o     (active_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_p = bit position in frame, m_cyc = clk cycle within the current bit.
    bit m_run = 1'b0;
    int m_cyc = 0, m_p = 0, m_div = 0, m_L = 0, m_N = 0, m_mode = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_cyc <= 0; m_p <= 0;
            m_div <= 0; m_L <= 0; m_N <= 0; m_mode <= 0;
        end else if (!m_run) begin
            if (enable) begin
                m_run <= 1'b1; m_cyc <= 0; m_p <= 0;
                m_div <= int'(div); m_L <= int'(slen); m_N <= int'(nsl); m_mode <= int'(mode);
            end
        end else if (m_cyc == 2 * m_div + 1) begin
            if (m_p == (m_N + 1) * (m_L + 1) - 1) begin
                if (!enable) begin
                    m_run <= 1'b0;
                end else begin
                    m_p <= 0; m_cyc <= 0;
                    m_div <= int'(div); m_L <= int'(slen); m_N <= int'(nsl); m_mode <= int'(mode);
                end
            end else begin
                m_p <= m_p + 1;
                m_cyc <= 0;
            end
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    int          c_half, c_bi, c_si, c_h, c_s1, c_s0;
    logic        c_lr;
    logic [14:0] c_ev, c_av;
    always @(negedge clk) begin
        if (!m_run) begin
            c_ev = '0;
        end else begin
            c_half = m_div + 1;
            c_bi   = m_p % (m_L + 1);
            c_si   = m_p / (m_L + 1);
            c_h    = (m_N + 2) / 2;
            c_s1   = (c_h - 1) * (m_L + 1) + m_L;
            c_s0   = m_N * (m_L + 1) + m_L;
            case (m_mode)
                1:       c_lr = (c_si < c_h);
                2:       c_lr = (m_p == 0);
                default: c_lr = (m_N != 0) && (m_p >= c_s1) && (m_p < c_s0);
            endcase
            c_ev = {1'b1, (m_cyc >= c_half), c_lr, (m_cyc == c_half), (m_cyc == 0),
                    (m_cyc == 0 && m_p == 0), 6'(c_bi), 3'(c_si)};
        end
        c_av = {active_o, bclk_o, lrclk_o, bclk_rise_o, bclk_fall_o, frame_start_o,
                bit_idx_o, slot_idx_o};
        check("cycle", {17'd0, c_av}, {17'd0, c_ev});
    end

    // ---------------- directed helpers ----------------
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start_o !== 1'b1 && n < 4000);
        if (n >= 4000) begin
            checks++;
            errors++;
            $display("FAIL wait_fs: no frame_start within %0d cycles, expected one", n);
        end
    endtask

    // Called on the cycle showing frame_start_o; returns on the next one.
    task automatic measure(output int cyc, output int falls, output int r_at,
                           output int f_at, output int lr_hi);
        int   fi;
        logic prev;
        cyc = 1; fi = 0; r_at = -1; f_at = -1;
        prev = lrclk_o; lr_hi = int'(lrclk_o);
        forever begin
            @(negedge clk);
            if (frame_start_o === 1'b1 || cyc >= 4000) break;
            cyc++;
            if (bclk_fall_o) fi++;
            if (lrclk_o && !prev) r_at = fi;
            if (!lrclk_o && prev) f_at = fi;
            lr_hi += int'(lrclk_o);
            prev = lrclk_o;
        end
        falls = fi + 1;
    endtask

    int n, cyc, falls, r_at, f_at, lr_hi, rises;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {17'd0, active_o, bclk_o, lrclk_o, bclk_rise_o, bclk_fall_o,
                                frame_start_o, bit_idx_o, slot_idx_o}, 32'd0);
        rst_n = 1'b1;

        // I2S, 2 x 16-bit slots, div 3
        div = 8'd3; slen = 6'd15; nsl = 3'd1; mode = 2'd0; enable = 1'b1;
        wait_fs(n);
        check("start_latency", n, 1);
        measure(cyc, falls, r_at, f_at, lr_hi);
        check("i2s_frame_cycles", cyc, 256);
        check("i2s_falls", falls, 32);
        check("i2s_lr_rise_fall_idx", r_at, 15);
        check("i2s_lr_fall_fall_idx", f_at, 31);

        // Divider change mid-frame only takes effect at the next boundary
        div = 8'd1;
        measure(cyc, falls, r_at, f_at, lr_hi);
        check("div_change_old_frame", cyc, 256);
        measure(cyc, falls, r_at, f_at, lr_hi);
        check("div_change_new_frame", cyc, 128);

        // Stop requested at slot 0 bit 5: frame completes, no extra rise
        cyc = 1; rises = 0;
        forever begin
            @(negedge clk);
            if (enable && bclk_fall_o && bit_idx_o == 6'd5 && slot_idx_o == 3'd0) enable = 1'b0;
            if (active_o == 1'b0 || cyc >= 4000) break;
            cyc++;
            rises += int'(bclk_rise_o);
        end
        check("stop_frame_cycles", cyc, 128);
        check("stop_frame_rises", rises, 32);
        check("stop_idle_lines", {29'd0, bclk_o, lrclk_o, active_o}, 32'd0);
        repeat (10) @(negedge clk);

        // Left-justified, 3 x 8-bit slots
        div = 8'd1; slen = 6'd7; nsl = 3'd2; mode = 2'd1; enable = 1'b1;
        wait_fs(n);
        measure(cyc, falls, r_at, f_at, lr_hi);
        check("lj_frame_cycles", cyc, 96);
        check("lj_falls", falls, 24);
        check("lj_lr_fall_idx", f_at, 16);

        // DSP, 8 x 32-bit slots at clk/2
        div = 8'd0; slen = 6'd31; nsl = 3'd7; mode = 2'd2;
        measure(cyc, falls, r_at, f_at, lr_hi);
        check("lj_to_dsp_old_frame", cyc, 96);
        measure(cyc, falls, r_at, f_at, lr_hi);
        check("dsp_frame_cycles", cyc, 512);
        check("dsp_falls", falls, 256);
        check("dsp_lr_high_cycles", lr_hi, 2);

        // Asynchronous reset between clock edges
        repeat (100) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset", {17'd0, active_o, bclk_o, lrclk_o, bclk_rise_o, bclk_fall_o,
                                 frame_start_o, bit_idx_o, slot_idx_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(n);
        check("restart_latency", n, 1);
        check("restart_position", {22'd0, bclk_fall_o, bit_idx_o, slot_idx_o}, 32'h200);

        // Randomized configurations, enables and mid-frame changes
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            div    = 8'($urandom_range(0, 3));
            slen   = 6'($urandom_range(0, 7));
            nsl    = 3'($urandom_range(0, 7));
            mode   = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(20, 700)) @(negedge clk);
        end
        enable = 1'b0;
        n = 0;
        while (active_o !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("final_idle", {31'd0, active_o}, 32'd0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
